// File: rtl/neopixel_strand_controller_p.sv
// neopixel_strand_controller_p
// Drives a WS2812-style NeoPixel strand from an internal colour frame buffer.
// Colours are written one channel at a time, to one pixel or broadcast to
// every pixel. A send request freezes a copy of the buffer and shifts it out
// as NRZ pulses, pixel 0 first, channels G,R,B(,W), MSB first, then holds
// the line low for the latch gap before accepting the next request.
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high reset
//   pixel_index    target pixel for a single-pixel load
//   color_index    channel select: 0=G, 1=R, 2=B, 3=W
//   color_level    intensity written by a load
//   load_color     write strobe
//   load_all       with load_color, write the channel of every pixel
//   send_it        start a frame when idle
//   neo_data       registered serial data to the strand
//   ready_to_load  buffer accepts writes
//   ready_to_send  controller idle, send_it will be taken
//   load_error     one-cycle pulse after a rejected load
module neopixel_strand_controller_p #(
   parameter int NUM_PIXELS = 5,
   parameter int CHANNELS   = 3,
   parameter int COLOR_BITS = 8,
   parameter int CLKS_T0H   = 17,
   parameter int CLKS_T1H   = 35,
   parameter int CLKS_BIT   = 62,
   parameter int CLKS_RESET = 2500,
   parameter int PIX_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [PIX_W-1:0]      pixel_index,
   input  logic [1:0]            color_index,
   input  logic [COLOR_BITS-1:0] color_level,
   input  logic                  load_color,
   input  logic                  load_all,
   input  logic                  send_it,
   output logic                  neo_data,
   output logic                  ready_to_load,
   output logic                  ready_to_send,
   output logic                  load_error
);

   localparam int TOTAL_BITS = NUM_PIXELS * CHANNELS * COLOR_BITS;
   localparam int BIT_W      = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
   localparam int CNT_MAX    = (CLKS_BIT > CLKS_RESET) ? CLKS_BIT : CLKS_RESET;
   localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [BIT_W-1:0] LAST_BIT       = BIT_W'(TOTAL_BITS - 1);
   localparam logic [CNT_W-1:0] BIT_CYC_LAST   = CNT_W'(CLKS_BIT - 1);
   localparam logic [CNT_W-1:0] LATCH_CYC_LAST = CNT_W'(CLKS_RESET - 1);
   localparam logic [CNT_W-1:0] T0H_CYCLES     = CNT_W'(CLKS_T0H);
   localparam logic [CNT_W-1:0] T1H_CYCLES     = CNT_W'(CLKS_T1H);
   localparam logic [2:0]       CHAN_LIMIT     = 3'(CHANNELS);
   localparam logic [PIX_W:0]   PIX_LIMIT      = (PIX_W + 1)'(NUM_PIXELS);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      LATCH
   } state_t;

   state_t                 state, state_next;
   logic [BIT_W-1:0]       bit_count, bit_next;
   logic [CNT_W-1:0]       cycle_count, cycle_next;
   logic                   neo_next;
   logic                   take_snapshot;
   logic                   tx_bit;

   logic [COLOR_BITS-1:0]  color_buf [NUM_PIXELS][CHANNELS];
   logic [COLOR_BITS-1:0]  buf_next  [NUM_PIXELS][CHANNELS];
   logic [TOTAL_BITS-1:0]  frame_next;
   logic [TOTAL_BITS-1:0]  shadow;

   logic                   chan_ok;
   logic                   pix_ok;
   logic                   load_ok;
   logic                   load_reject;

   // Writes are never blocked; the buffer is a plain register file that the
   // serialiser only reads through its own shadow copy.
   assign ready_to_load = 1'b1;
   assign ready_to_send = (state == IDLE);

   // A load is legal only for an existing channel and, unless broadcast, an
   // existing pixel. Anything else is dropped and flagged on the next cycle.
   assign chan_ok     = ({1'b0, color_index} < CHAN_LIMIT);
   assign pix_ok      = load_all || ({1'b0, pixel_index} < PIX_LIMIT);
   assign load_ok     = load_color && chan_ok && pix_ok;
   assign load_reject = load_color && !load_ok;

   // Buffer contents as they will be after this edge. Building this
   // combinationally lets the snapshot taken on a send edge include a load
   // issued in the very same cycle.
   always_comb begin
      buf_next = color_buf;
      for (int p = 0; p < NUM_PIXELS; p++) begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (load_ok && (color_index == 2'(c)) &&
                (load_all || (pixel_index == PIX_W'(p)))) begin
               buf_next[p][c] = color_level;
            end
         end
      end
   end

   // Flatten the next buffer into transmission order so the serialiser can
   // simply walk bit index 0..TOTAL_BITS-1: pixel-major, then channel, and
   // MSB of each channel first.
   always_comb begin
      frame_next = '0;
      for (int p = 0; p < NUM_PIXELS; p++) begin
         for (int c = 0; c < CHANNELS; c++) begin
            for (int b = 0; b < COLOR_BITS; b++) begin
               frame_next[(p * CHANNELS + c) * COLOR_BITS + b] =
                  buf_next[p][c][COLOR_BITS - 1 - b];
            end
         end
      end
   end

   // Next-state logic. The line value is computed for the counters being
   // entered, so neo_data is a clean register output that goes high in the
   // cycle right after a send is accepted.
   always_comb begin
      state_next    = state;
      bit_next      = bit_count;
      cycle_next    = cycle_count;
      take_snapshot = 1'b0;
      neo_next      = 1'b0;
      tx_bit        = 1'b0;

      case (state)
         IDLE: begin
            if (send_it) begin
               state_next    = SEND;
               bit_next      = '0;
               cycle_next    = '0;
               take_snapshot = 1'b1;
            end
         end
         SEND: begin
            if (cycle_count == BIT_CYC_LAST) begin
               cycle_next = '0;
               if (bit_count == LAST_BIT) begin
                  state_next = LATCH;
                  bit_next   = '0;
               end else begin
                  bit_next = bit_count + 1'b1;
               end
            end else begin
               cycle_next = cycle_count + 1'b1;
            end
         end
         LATCH: begin
            if (cycle_count == LATCH_CYC_LAST) begin
               state_next = IDLE;
               cycle_next = '0;
            end else begin
               cycle_next = cycle_count + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            bit_next   = '0;
            cycle_next = '0;
         end
      endcase

      if (state_next == SEND) begin
         tx_bit   = take_snapshot ? frame_next[bit_next] : shadow[bit_next];
         neo_next = (cycle_next < (tx_bit ? T1H_CYCLES : T0H_CYCLES));
      end
   end

   // State, counters, line and error registers. Reset drops the line at once,
   // abandoning any frame in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         bit_count   <= '0;
         cycle_count <= '0;
         neo_data    <= 1'b0;
         load_error  <= 1'b0;
      end else begin
         state       <= state_next;
         bit_count   <= bit_next;
         cycle_count <= cycle_next;
         neo_data    <= neo_next;
         load_error  <= load_reject;
      end
   end

   // Colour buffer and transmit shadow. The shadow is only refreshed when a
   // frame starts, so later loads wait for the following frame.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shadow <= '0;
         for (int p = 0; p < NUM_PIXELS; p++) begin
            for (int c = 0; c < CHANNELS; c++) begin
               color_buf[p][c] <= '0;
            end
         end
      end else begin
         color_buf <= buf_next;
         if (take_snapshot) begin
            shadow <= frame_next;
         end
      end
   end

endmodule

// File: tb/tb_neopixel_strand_controller_p.sv
// tb_neopixel_strand_controller_p
// Two controllers share one clock: instance 0 is the default 5-pixel GRB
// strand, instance 1 a 2-pixel GRBW strand. Stimulus threads update a
// per-instance colour model and queue the expected frame at each accepted
// send and the expected load_error for each load. A monitor decodes neo_data
// pulse widths back into bits and checks each completed frame against the
// queue, together with pulse widths, bit periods and total frame duration.
module tb_neopixel_strand_controller_p;

   localparam int T0H   = 17;
   localparam int T1H   = 35;
   localparam int TBIT  = 62;
   localparam int TRST  = 2500;
   localparam int WAIT_BUDGET = 12000;

   typedef struct {
      logic [127:0] bits;
      int           len;
   } frame_t;

   logic       clock;
   logic       reset_s       [2];
   logic [2:0] pixel_index_s [2];
   logic [1:0] color_index_s [2];
   logic [7:0] color_level_s [2];
   logic       load_color_s  [2];
   logic       load_all_s    [2];
   logic       send_it_s     [2];
   logic       neo_s         [2];
   logic       rtl_s         [2];
   logic       rts_s         [2];
   logic       lerr_s        [2];

   int tests_run = 0;
   int tests_failed = 0;
   int cyc_n = 0;

   byte unsigned model_buf [2][5][4];
   frame_t       exp_q [2][$];
   bit           err_q [2][$];

   bit           prev_d [2];
   bit           prev_rts [2];
   bit           in_frame [2];
   bit           load_pending [2];
   bit           expect_b2b [2];
   int           high_len [2];
   int           period_len [2];
   int           rx_count [2];
   int           start_cyc [2];
   int           bad_high [2];
   int           bad_period [2];
   int           last_end [2];
   int           frames_seen [2];
   logic [127:0] rx_bits [2];

   neopixel_strand_controller_p dut_a (
      .clock         (clock),
      .reset         (reset_s[0]),
      .pixel_index   (pixel_index_s[0]),
      .color_index   (color_index_s[0]),
      .color_level   (color_level_s[0]),
      .load_color    (load_color_s[0]),
      .load_all      (load_all_s[0]),
      .send_it       (send_it_s[0]),
      .neo_data      (neo_s[0]),
      .ready_to_load (rtl_s[0]),
      .ready_to_send (rts_s[0]),
      .load_error    (lerr_s[0])
   );

   neopixel_strand_controller_p #(
      .NUM_PIXELS (2),
      .CHANNELS   (4)
   ) dut_b (
      .clock         (clock),
      .reset         (reset_s[1]),
      .pixel_index   (pixel_index_s[1][0]),
      .color_index   (color_index_s[1]),
      .color_level   (color_level_s[1]),
      .load_color    (load_color_s[1]),
      .load_all      (load_all_s[1]),
      .send_it       (send_it_s[1]),
      .neo_data      (neo_s[1]),
      .ready_to_load (rtl_s[1]),
      .ready_to_send (rts_s[1]),
      .load_error    (lerr_s[1])
   );

   // Free-running clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic int npx(input int id);
      return (id == 0) ? 5 : 2;
   endfunction

   function automatic int nch(input int id);
      return (id == 0) ? 3 : 4;
   endfunction

   // Colour model: returns the expected load_error for this load.
   function automatic bit model_load(input int id, input int pix, input int ch,
                                     input byte unsigned lvl, input bit all);
      if (ch >= nch(id) || (!all && pix >= npx(id))) return 1'b1;
      for (int p = 0; p < npx(id); p++) begin
         if (all || p == pix) model_buf[id][p][ch] = lvl;
      end
      return 1'b0;
   endfunction

   // Expected frame: walk pixels, channels, then bits MSB first.
   function automatic frame_t build_frame(input int id);
      frame_t f;
      int k;
      f.bits = '0;
      k = 0;
      for (int p = 0; p < npx(id); p++) begin
         for (int c = 0; c < nch(id); c++) begin
            for (int b = 7; b >= 0; b--) begin
               f.bits[k] = model_buf[id][p][c][b];
               k++;
            end
         end
      end
      f.len = k;
      return f;
   endfunction

   task automatic check_output(input string name, input int actual, input int expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic check_bits(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Closes a decoded frame and compares it with the oldest queued one.
   task automatic end_frame(input int id);
      frame_t exp;
      in_frame[id] = 1'b0;
      last_end[id] = cyc_n;
      frames_seen[id]++;
      if (exp_q[id].size() == 0) begin
         check_output($sformatf("dut%0d unexpected frame", id), 1, 0);
      end else begin
         exp = exp_q[id].pop_front();
         check_output($sformatf("dut%0d frame length", id), rx_count[id], exp.len);
         check_bits($sformatf("dut%0d frame bits", id), rx_bits[id], exp.bits);
         check_output($sformatf("dut%0d bad high widths", id), bad_high[id], 0);
         check_output($sformatf("dut%0d bad bit periods", id), bad_period[id], 0);
         check_output($sformatf("dut%0d frame duration", id),
                      cyc_n - start_cyc[id], exp.len * TBIT + TRST);
      end
   endtask

   // Per-cycle monitor step for one instance, sampled on the falling edge.
   task automatic monitor_step(input int id);
      bit d;
      bit rts;
      bit bitv;
      d   = neo_s[id];
      rts = rts_s[id];
      if (reset_s[id]) begin
         in_frame[id]     = 1'b0;
         load_pending[id] = 1'b0;
         prev_d[id]       = d;
         prev_rts[id]     = rts;
         return;
      end

      if (load_pending[id]) begin
         if (err_q[id].size() == 0)
            check_output($sformatf("dut%0d load_error queue", id), 0, 1);
         else
            check_output($sformatf("dut%0d load_error", id), lerr_s[id], err_q[id].pop_front());
      end else if (lerr_s[id] !== 1'b0) begin
         check_output($sformatf("dut%0d load_error spurious", id), lerr_s[id], 0);
      end
      load_pending[id] = load_color_s[id];

      if (d && !prev_d[id]) begin
         if (in_frame[id]) begin
            if (period_len[id] != TBIT) bad_period[id]++;
         end else begin
            in_frame[id]   = 1'b1;
            start_cyc[id]  = cyc_n;
            rx_count[id]   = 0;
            rx_bits[id]    = '0;
            bad_high[id]   = 0;
            bad_period[id] = 0;
            if (expect_b2b[id]) begin
               check_output($sformatf("dut%0d back-to-back idle gap", id),
                            cyc_n - last_end[id], 1);
               expect_b2b[id] = 1'b0;
            end
         end
         period_len[id] = 1;
         high_len[id]   = 1;
      end else if (in_frame[id]) begin
         period_len[id]++;
         if (d) begin
            high_len[id]++;
         end else if (prev_d[id]) begin
            if (high_len[id] == T1H) bitv = 1'b1;
            else if (high_len[id] == T0H) bitv = 1'b0;
            else begin
               bad_high[id]++;
               bitv = (high_len[id] > (T0H + T1H) / 2);
            end
            if (rx_count[id] < 128) rx_bits[id][rx_count[id]] = bitv;
            rx_count[id]++;
         end
      end

      if (rts && !prev_rts[id] && in_frame[id]) end_frame(id);
      prev_d[id]   = d;
      prev_rts[id] = rts;
   endtask

   always @(negedge clock) begin
      cyc_n++;
      monitor_step(0);
      monitor_step(1);
   end

   task automatic wait_ready(input int id, input string name);
      int n;
      n = 0;
      while (rts_s[id] !== 1'b1 && n < WAIT_BUDGET) begin
         cyc(1);
         n++;
      end
      if (rts_s[id] !== 1'b1)
         check_output($sformatf("dut%0d %s ready timeout", id, name), 0, 1);
   endtask

   task automatic apply_stimulus_load(input int id, input int pix, input int ch,
                                      input int lvl, input bit all);
      pixel_index_s[id] = 3'(pix);
      color_index_s[id] = 2'(ch);
      color_level_s[id] = 8'(lvl);
      load_all_s[id]    = all;
      load_color_s[id]  = 1'b1;
      err_q[id].push_back(model_load(id, pix, ch, 8'(lvl), all));
      cyc(1);
      load_color_s[id] = 1'b0;
      load_all_s[id]   = 1'b0;
   endtask

   // Starts a frame, optionally with a load in the same cycle.
   task automatic apply_stimulus_send(input int id, input bit with_load, input int pix,
                                      input int ch, input int lvl);
      wait_ready(id, "send");
      if (with_load) begin
         pixel_index_s[id] = 3'(pix);
         color_index_s[id] = 2'(ch);
         color_level_s[id] = 8'(lvl);
         load_color_s[id]  = 1'b1;
         err_q[id].push_back(model_load(id, pix, ch, 8'(lvl), 1'b0));
      end
      send_it_s[id] = 1'b1;
      exp_q[id].push_back(build_frame(id));
      cyc(1);
      send_it_s[id]    = 1'b0;
      load_color_s[id] = 1'b0;
   endtask

   // Reset in the middle of a frame: the line must drop at once.
   task automatic apply_stimulus_abort(input int id);
      reset_s[id] = 1'b1;
      #1;
      check_output($sformatf("dut%0d neo_data at reset", id), neo_s[id], 0);
      check_output($sformatf("dut%0d ready_to_send at reset", id), rts_s[id], 1);
      if (exp_q[id].size() > 0) void'(exp_q[id].pop_back());
      for (int p = 0; p < 5; p++)
         for (int c = 0; c < 4; c++)
            model_buf[id][p][c] = 8'h00;
      cyc(2);
      reset_s[id] = 1'b0;
      cyc(1);
   endtask

   initial begin
      repeat (150000) @(posedge clock);
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         reset_s[i]       = 1'b0;
         pixel_index_s[i] = '0;
         color_index_s[i] = '0;
         color_level_s[i] = '0;
         load_color_s[i]  = 1'b0;
         load_all_s[i]    = 1'b0;
         send_it_s[i]     = 1'b0;
         for (int p = 0; p < 5; p++)
            for (int c = 0; c < 4; c++)
               model_buf[i][p][c] = 8'h00;
      end
      #1;
      reset_s[0] = 1'b1;
      reset_s[1] = 1'b1;
      cyc(3);
      for (int i = 0; i < 2; i++) begin
         check_output($sformatf("dut%0d reset neo_data", i), neo_s[i], 0);
         check_output($sformatf("dut%0d reset ready_to_send", i), rts_s[i], 1);
         check_output($sformatf("dut%0d reset load_error", i), lerr_s[i], 0);
      end
      reset_s[0] = 1'b0;
      reset_s[1] = 1'b0;
      cyc(1);
      check_output("dut0 ready_to_load", rtl_s[0], 1);
      check_output("dut1 ready_to_load", rtl_s[1], 1);

      fork
         begin : thread_a
            apply_stimulus_load(0, 4, 1, 'hFF, 1'b0);
            apply_stimulus_load(0, 1, 2, 'hA0, 1'b0);
            apply_stimulus_load(0, 2, 0, 'hB3, 1'b0);
            apply_stimulus_send(0, 1'b0, 0, 0, 0);
            cyc(600);
            check_output("dut0 ready_to_send during send", rts_s[0], 0);
            send_it_s[0] = 1'b1;
            cyc(1);
            send_it_s[0] = 1'b0;
            apply_stimulus_load(0, 0, 0, 'hFF, 1'b0);
            apply_stimulus_send(0, 1'b0, 0, 0, 0);
            apply_stimulus_send(0, 1'b0, 0, 0, 0);
            cyc(999);
            apply_stimulus_abort(0);
            apply_stimulus_load(0, 0, 3, 'h55, 1'b0);
            apply_stimulus_load(0, 6, 0, 'h77, 1'b0);
            apply_stimulus_send(0, 1'b0, 0, 0, 0);
            apply_stimulus_load(0, 3, 1, 'h80, 1'b1);
            wait_ready(0, "held send");
            send_it_s[0] = 1'b1;
            exp_q[0].push_back(build_frame(0));
            cyc(1);
            repeat (20) begin
               cyc($urandom_range(1, 80));
               apply_stimulus_load(0, $urandom_range(0, 6), $urandom_range(0, 3),
                                   $urandom_range(0, 255), ($urandom_range(0, 7) == 0));
            end
            wait_ready(0, "held repeat");
            exp_q[0].push_back(build_frame(0));
            expect_b2b[0] = 1'b1;
            cyc(1);
            send_it_s[0] = 1'b0;
            cyc(2);
            wait_ready(0, "final");
         end
         begin : thread_b
            apply_stimulus_load(1, 1, 3, 'h01, 1'b0);
            apply_stimulus_send(1, 1'b0, 0, 0, 0);
            for (int it = 0; it < 5; it++) begin
               repeat ($urandom_range(1, 6)) begin
                  cyc($urandom_range(0, 30));
                  apply_stimulus_load(1, $urandom_range(0, 1), $urandom_range(0, 3),
                                      $urandom_range(0, 255), ($urandom_range(0, 3) == 0));
               end
               apply_stimulus_send(1, (it % 2) == 1, $urandom_range(0, 1),
                                   $urandom_range(0, 3), $urandom_range(0, 255));
            end
            cyc(2);
            wait_ready(1, "final");
         end
      join

      cyc(20);
      check_output("dut0 frames pending", exp_q[0].size(), 0);
      check_output("dut1 frames pending", exp_q[1].size(), 0);
      check_output("dut0 load results pending", err_q[0].size(), 0);
      check_output("dut1 load results pending", err_q[1].size(), 0);
      check_output("dut0 frames seen", frames_seen[0], 5);
      check_output("dut1 frames seen", frames_seen[1], 6);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
